// File: rtl/hll_bucket_updater.sv
// hll_bucket_updater
//   Splits each incoming hash into a bucket index (top P bits) and a rank
//   (leading zeros of the remaining W bits, plus one). It keeps the 2^P-entry
//   HLL max-register array in RAM, updated by a three-stage read-modify-write
//   pipeline with forwarding. A small FSM clears the array after reset or on
//   request, draining in-flight updates first.
// Ports
//   clk, reset      : clock and synchronous active-high reset (reset runs a full clear)
//   hash_input/valid: hash stream; hash_ready is high only in IDLE
//   clear_start     : request to zero the array (honoured in IDLE only)
//   clear_busy      : high during DRAIN and CLEAR
//   rd_en/rd_addr   : register readout; rd_data/rd_valid one cycle later
//   update_count    : saturating count of accepted hashes since the last clear
//   zero_count      : number of registers still equal to zero
module hll_bucket_updater #(
  parameter int P          = 12,
  parameter int HASH_WIDTH = 64,
  parameter int RANK_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HASH_WIDTH-1:0] hash_input,
  input  logic                  hash_valid,
  output logic                  hash_ready,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  rd_en,
  input  logic [P-1:0]          rd_addr,
  output logic [RANK_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [31:0]           update_count,
  output logic [P:0]            zero_count
);

  localparam int W     = HASH_WIDTH - P;
  localparam int DEPTH = 1 << P;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Rank = leading zeros of the tail + 1; the highest set bit wins because
  // the loop walks upward and overwrites. An all-zero tail gives W+1.
  function automatic logic [RANK_WIDTH-1:0] rank_of(input logic [W-1:0] tail);
    logic [RANK_WIDTH-1:0] r;
    r = RANK_WIDTH'(W + 1);
    for (int i = 0; i < W; i++) begin
      if (tail[i]) begin
        r = RANK_WIDTH'(W - i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [P-1:0]          clr_addr_q, clr_addr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [P-1:0]          s1_bucket_q, s1_bucket_d;
  logic [RANK_WIDTH-1:0] s1_rank_q, s1_rank_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [P-1:0]          s2_bucket_q, s2_bucket_d;
  logic [RANK_WIDTH-1:0] s2_rank_q, s2_rank_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [RANK_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [31:0]           update_count_q, update_count_d;
  logic [P:0]            zero_count_q, zero_count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [RANK_WIDTH-1:0] rd_data_q;
  logic [RANK_WIDTH-1:0] upd_rd_q;

  logic                  accept_s;
  logic                  rd_hon_s;
  logic                  enter_clear_s;
  logic [RANK_WIDTH-1:0] s2_old_s;
  logic [RANK_WIDTH-1:0] s2_new_s;
  logic                  wr_en_s;
  logic [P-1:0]          wr_addr_s;
  logic [RANK_WIDTH-1:0] wr_data_s;

  logic [RANK_WIDTH-1:0] mem [DEPTH];

  // FSM outputs and handshake qualifiers
  always_comb begin
    hash_ready = (state_q == ST_IDLE);
    clear_busy = (state_q != ST_IDLE);
    accept_s   = hash_valid && (state_q == ST_IDLE);
    rd_hon_s   = rd_en && (state_q == ST_IDLE);
  end

  // FSM next state. Leaving DRAIN only needs S1 empty: a valid S2 makes its
  // final write on the same edge that enters CLEAR, and the clear then
  // overwrites everything anyway.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = {P{1'b0}};
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + {{(P-1){1'b0}}, 1'b1};
        if (clr_addr_q == {P{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (clear_start && (accept_s || s1_valid_q)) begin
          state_d = ST_DRAIN;
        end else if (clear_start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Pipeline: S0 -> S1 (RAM read issued) -> S2 (compare and write)
  always_comb begin
    s1_valid_d  = accept_s;
    s1_bucket_d = hash_input[HASH_WIDTH-1 -: P];
    s1_rank_d   = rank_of(hash_input[W-1:0]);
    s2_valid_d  = s1_valid_q;
    s2_bucket_d = s1_bucket_q;
    s2_rank_d   = s1_rank_q;
    // RAM output is stale when S2 wrote the same bucket on the S1 read edge.
    s2_old_s    = fwd_valid_q ? fwd_data_q : upd_rd_q;
    if (s2_rank_q > s2_old_s) begin
      s2_new_s = s2_rank_q;
    end else begin
      s2_new_s = s2_old_s;
    end
    fwd_valid_d = s2_valid_q && s1_valid_q && (s1_bucket_q == s2_bucket_q);
    fwd_data_d  = s2_new_s;
  end

  // Single RAM write port shared by the clear sweep and S2
  always_comb begin
    if (state_q == ST_CLEAR) begin
      wr_en_s   = !reset;
      wr_addr_s = clr_addr_q;
      wr_data_s = {RANK_WIDTH{1'b0}};
    end else begin
      wr_en_s   = s2_valid_q && !reset;
      wr_addr_s = s2_bucket_q;
      wr_data_s = s2_new_s;
    end
  end

  // Counters and readout valid
  always_comb begin
    enter_clear_s  = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
    update_count_d = update_count_q;
    zero_count_d   = zero_count_q;
    if (enter_clear_s) begin
      update_count_d = 32'd0;
      zero_count_d   = (P+1)'(DEPTH);
    end else begin
      if (accept_s && (update_count_q != 32'hFFFF_FFFF)) begin
        update_count_d = update_count_q + 32'd1;
      end else begin
        update_count_d = update_count_q;
      end
      if (s2_valid_q && (s2_old_s == {RANK_WIDTH{1'b0}})) begin
        zero_count_d = zero_count_q - {{P{1'b0}}, 1'b1};
      end else begin
        zero_count_d = zero_count_q;
      end
    end
    rd_valid_d = rd_hon_s;
  end

  // State, pipeline and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= {P{1'b0}};
      s1_valid_q     <= 1'b0;
      s1_bucket_q    <= {P{1'b0}};
      s1_rank_q      <= {RANK_WIDTH{1'b0}};
      s2_valid_q     <= 1'b0;
      s2_bucket_q    <= {P{1'b0}};
      s2_rank_q      <= {RANK_WIDTH{1'b0}};
      fwd_valid_q    <= 1'b0;
      fwd_data_q     <= {RANK_WIDTH{1'b0}};
      update_count_q <= 32'd0;
      zero_count_q   <= (P+1)'(DEPTH);
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      s1_valid_q     <= s1_valid_d;
      s1_bucket_q    <= s1_bucket_d;
      s1_rank_q      <= s1_rank_d;
      s2_valid_q     <= s2_valid_d;
      s2_bucket_q    <= s2_bucket_d;
      s2_rank_q      <= s2_rank_d;
      fwd_valid_q    <= fwd_valid_d;
      fwd_data_q     <= fwd_data_d;
      update_count_q <= update_count_d;
      zero_count_q   <= zero_count_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

  // RAM read port for the update pipeline (read-before-write)
  always_ff @(posedge clk) begin
    upd_rd_q <= mem[s1_bucket_q];
  end

  // RAM read port for readout (read-before-write)
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= {RANK_WIDTH{1'b0}};
    end else if (rd_hon_s) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign update_count = update_count_q;
  assign zero_count   = zero_count_q;

endmodule

// File: doc/hll_bucket_updater.md
# hll_bucket_updater

Upstream rank-extraction and register-update stage of the adaptive HLL path. Accepts a stream of 64-bit hashes and splits each into a P-bit bucket index and a rank (leading-zero count + 1). Maintains the 2^P-entry HLL max-register array in on-chip RAM through a fully pipelined read-modify-write with hazard forwarding. Exposes per-bucket register values, an empty-bucket count and an update count to the adaptive cell array and estimator downstream.

## Interface

Parameters
- P, 12, bucket index width; array depth 2^P
- HASH_WIDTH, 64, input hash width; W = HASH_WIDTH-P rank bits
- RANK_WIDTH, 6, register width; must satisfy W+1 <= 2^RANK_WIDTH-1

Ports (one clock; reset is synchronous and active-high)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- hash_input  in  HASH_WIDTH  hash word
- hash_valid  in  1  hash_input valid
- hash_ready  out  1  hash accepted on a cycle with hash_valid && hash_ready
- clear_start  in  1  single-cycle request to zero the array
- clear_busy  out  1  high while clear is pending or in progress
- rd_en  in  1  readout request
- rd_addr  in  P  readout bucket
- rd_data  out  RANK_WIDTH  register value; valid when rd_valid
- rd_valid  out  1  one-cycle pulse, one cycle after an honoured rd_en
- update_count  out  32  accepted hashes since last clear, saturating at 2^32-1
- zero_count  out  P+1  number of registers equal to 0

## Operation

- bucket = hash_input[HASH_WIDTH-1 -: P]; tail = hash_input[W-1:0].
- rank = (leading zeros of tail, counted from bit W-1) + 1; tail == 0 gives rank = W+1 (53 at defaults). rank is always >= 1.
- Update: reg[bucket] <= max(reg[bucket], rank). The array state must equal strictly sequential application of all accepted hashes.
- Pipeline stages:
  - S0: accept and compute bucket/rank.
  - S1: synchronous RAM read.
  - S2: compare and write.
- RAM: 1 write port and 2 read ports (update, readout).
- Forwarding: if S2 writes bucket B in the same cycle S1 reads B, S2 of the next cycle uses the written value instead of the RAM output. Back-to-back updates to the same bucket are correct at full throughput.
- zero_count decrements by 1 when S2 writes a register whose pre-update value (after forwarding) was 0.
- update_count increments on every accept.
- FSM states:
  - CLEAR: write 0 to addresses 0..2^P-1 in order, one per cycle. Then go to IDLE.
  - IDLE: hash_ready=1. clear_start goes to DRAIN.
  - DRAIN: hash_ready=0; wait until S1 and S2 are empty, then go to CLEAR.
- hash_ready=0 and clear_busy=1 in DRAIN and CLEAR. clear_start outside IDLE is ignored.
- clear_start and a hash accept in the same IDLE cycle: the hash is accepted, completes, and is then cleared.
- On entering CLEAR: update_count <= 0; zero_count <= 2^P, held through CLEAR.
- Readout: rd_en honoured only when clear_busy=0; otherwise rd_valid stays 0. A readout of an address written in the same cycle returns the pre-write value.

## Timing

- While reset is high and on the first cycle after release:
  - hash_ready=0, clear_busy=1, rd_valid=0, rd_data=0
  - update_count=0, zero_count=2^P
  - pipeline valids cleared, FSM=CLEAR at address 0
- Reset therefore always runs a full clear. Reset asserted mid-clear or mid-update aborts and restarts the clear from address 0; in-flight hashes are discarded.
- CLEAR lasts exactly 2^P cycles. clear_busy falls and hash_ready rises on the same cycle.
- Hash accepted at edge t:
  - RAM write at edge t+2.
  - zero_count and update_count: update_count changes at edge t; zero_count changes at edge t+2.
  - rd_en at cycle t+2 or later (sampled edge t+3) returns the new value.
- Throughput: one hash per cycle in IDLE; no internal backpressure.
- rd_en sampled at edge t gives rd_data/rd_valid at edge t+1.
- DRAIN lasts 0–2 cycles depending on pipeline occupancy.

## Test plan

- Reset, hold 4096 cycles until clear_busy=0 -> hash_ready=1; reading addresses 0, 0x7FF, 0xFFF returns 0; zero_count=4096; update_count=0.
- Single hash 0x1232_0000_0000_0000 (bucket 0x123, tail bit 49 highest set) -> rank 3; read 0x123 returns 3 three cycles later; zero_count=4095; update_count=1.
- Back-to-back, no gaps, bucket 0x055 with ranks 2, 5, 1, then bucket 0x056 rank 4 -> reg[0x055]=5, reg[0x056]=4, zero_count=4094. Confirms the forwarding path.
- Hash 0xABC0_0000_0000_0000 (tail zero) -> reg[0xABC]=53.
- Stream 10 hashes with clear_start pulsed on the 6th accept -> hash_ready drops next cycle and DRAIN completes. clear_busy stays high until 2^P cycles of CLEAR end. Afterwards all reads return 0, update_count=0, zero_count=4096.
- Reset asserted mid-CLEAR at address 0x800 -> clear restarts from address 0 and lasts a full 4096 cycles. rd_en during clear gives rd_valid=0.
